// File: rtl/uart_rx_core.sv
// UART receive core: synchronizes UART_Rx, reassembles start/8 data/optional parity/stop
// frames LSB first and strobes each byte with its parity and framing status.
`timescale 1ns/1ps
module uart_rx_core #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start_rx,
  input  logic [7:0]        clk_ratio,
  input  logic              parityen,
  input  logic              parityodd,
  input  logic              UART_Rx,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy_rx
);

  // state  | meaning
  // IDLE   | waiting for a falling edge on the synchronized line
  // START  | timing to mid start bit to reject glitches
  // DATA   | sampling data bits at mid bit, LSB first
  // PARITY | sampling the parity bit
  // STOP   | sampling the stop bit, strobing the result
  // BREAK  | stop bit was low; wait for the line to go idle
  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_BREAK
  } state_t;

  state_t            state, state_nxt;
  logic [SYNC_STAGES-1:0] sync;
  logic              rxs, rxs_d;
  logic [7:0]        ratio_l, bit_cnt;
  logic [3:0]        bit_idx;
  logic [DATA_W-1:0] shift;
  logic              pen_l, podd_l, perr_l;
  logic              tick, start_ok, stop_samp;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) sync <= '1;
    else          sync <= {sync[SYNC_STAGES-2:0], UART_Rx};
  end

  assign rxs = sync[SYNC_STAGES-1];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start_ok  = 1'b0;
    stop_samp = 1'b0;
    busy_rx   = 1'b0;
    tick      = (bit_cnt == 8'd0);
    case (state)
      ST_IDLE: begin
        if (start_rx && (clk_ratio >= 8'd4) && !rxs && rxs_d) begin
          start_ok  = 1'b1;
          state_nxt = ST_START;
        end
      end
      ST_START: begin
        busy_rx = 1'b1;
        if (tick) state_nxt = rxs ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        busy_rx = 1'b1;
        if (tick && (bit_idx == 4'(DATA_W - 1)))
          state_nxt = pen_l ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: begin
        busy_rx = 1'b1;
        if (tick) state_nxt = ST_STOP;
      end
      ST_STOP: begin
        busy_rx = 1'b1;
        if (tick) begin
          stop_samp = 1'b1;
          state_nxt = rxs ? ST_IDLE : ST_BREAK;
        end
      end
      ST_BREAK: begin
        if (rxs) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Timer is loaded to land on mid start bit, then reloaded with a full bit each sample.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rxs_d      <= 1'b1;
      ratio_l    <= '0;
      pen_l      <= 1'b0;
      podd_l     <= 1'b0;
      bit_cnt    <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      perr_l     <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rxs_d      <= rxs;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      if (start_ok) begin
        ratio_l <= clk_ratio;
        pen_l   <= parityen;
        podd_l  <= parityodd;
        bit_cnt <= (clk_ratio >> 1) - 8'd1;
        bit_idx <= '0;
        perr_l  <= 1'b0;
      end else if (busy_rx) begin
        if (tick) bit_cnt <= ratio_l - 8'd1;
        else      bit_cnt <= bit_cnt - 8'd1;
        if (tick && (state == ST_DATA)) begin
          shift   <= {rxs, shift[DATA_W-1:1]};
          bit_idx <= bit_idx + 4'd1;
        end
        // parityodd=0 demands an odd count of ones, parityodd=1 an even count
        if (tick && (state == ST_PARITY))
          perr_l <= (^shift) ^ rxs ^ ~podd_l;
        if (stop_samp) begin
          data_valid <= 1'b1;
          data_out   <= shift;
          parity_err <= perr_l;
          frame_err  <= ~rxs;
        end
      end
    end
  end

endmodule
